// File: rtl/fir_sample_pacer.sv
// Sample pacer: buffers upstream samples in a FIFO and releases one every RATIO
// fast cycles as x with a strobe, an underflow flag and the slow sample clock.
module fir_sample_pacer #(
  parameter int DATA_W = 8,
  parameter int RATIO  = 25,
  parameter int DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic signed [DATA_W-1:0]    s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic signed [DATA_W-1:0]    x,
  output logic                        x_stb,
  output logic                        clk_out,
  output logic                        underflow,
  output logic [$clog2(DEPTH+1)-1:0]  level
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int PHW = $clog2(RATIO);

  localparam logic [PHW-1:0] PH_LAST  = PHW'(RATIO - 1);
  localparam logic [PHW-1:0] PH_FALL  = PHW'(RATIO / 2 - 1);
  localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            level_q, level_d;
  logic [PHW-1:0]           phase_q, phase_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic                     x_stb_q, x_stb_d;
  logic                     clk_out_q, clk_out_d;
  logic                     underflow_q, underflow_d;

  logic push, pop, tick, empty;

  // Full/empty come only from the registered level, so a pop never frees a slot
  // for a push in the same cycle.
  assign empty = (level_q == '0);
  assign push  = s_valid && (level_q != LVL_FULL);
  assign tick  = enable && (phase_q == PH_LAST);
  assign pop   = tick && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    phase_d     = phase_q;
    x_d         = x_q;
    clk_out_d   = clk_out_q;
    x_stb_d     = tick;
    underflow_d = tick && empty;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (enable) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PHW'(1);
      if (tick)                    clk_out_d = 1'b1;
      else if (phase_q == PH_FALL) clk_out_d = 1'b0;
    end

    // An empty FIFO at the tick is zero-stuffed rather than skipped.
    if (tick) x_d = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      phase_q     <= '0;
      x_q         <= '0;
      x_stb_q     <= 1'b0;
      clk_out_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      phase_q     <= phase_d;
      x_q         <= x_d;
      x_stb_q     <= x_stb_d;
      clk_out_q   <= clk_out_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= s_data;
  end

  assign s_ready   = (level_q != LVL_FULL);
  assign x         = x_q;
  assign x_stb     = x_stb_q;
  assign clk_out   = clk_out_q;
  assign underflow = underflow_q;
  assign level     = level_q;

endmodule

// File: tb/tb_fir_sample_pacer.sv
// Directed bench for fir_sample_pacer: reset, pacing, full, empty edge, stall
// and mid-operation reset, with hand-computed expectations.
module tb_fir_sample_pacer;

  logic              clk = 1'b0;
  logic              rst, enable, s_valid;
  logic signed [7:0] s_data;
  logic              s_ready, x_stb, clk_out, underflow;
  logic signed [7:0] x;
  logic [3:0]        level;

  int errors = 0;
  int checks = 0;

  fir_sample_pacer #(.DATA_W(8), .RATIO(25), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .x(x), .x_stb(x_stb), .clk_out(clk_out),
    .underflow(underflow), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic next_stb(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (x_stb !== 1'b1 && n < 100);
  endtask

  int n, hi, lo;

  initial begin
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;

    // Reset
    step(); step();
    chk("rst_x", x, 0);
    chk("rst_x_stb", x_stb, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_level", level, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_underflow", underflow, 0);

    // Pacing: four back-to-back pushes, first strobe 25 edges after reset
    rst = 1'b0; enable = 1'b1; s_valid = 1'b1;
    s_data = 8'sd5;   step();
    s_data = -8'sd3;  step();
    s_data = 8'sd127; step();
    s_data = -8'sd128; step();
    s_valid = 1'b0;
    chk("pace_level4", level, 4);
    next_stb(n);
    chk("pace_first_latency", n + 4, 25);
    chk("pace_x0", x, 5);
    chk("pace_uf0", underflow, 0);
    chk("pace_clk_rise", clk_out, 1);
    chk("pace_level3", level, 3);
    hi = 0;
    while (clk_out === 1'b1 && hi < 50) begin step(); hi++; end
    chk("clk_high_cycles", hi, 12);
    chk("x_held", x, 5);
    chk("stb_pulse", x_stb, 0);
    chk("uf_idle", underflow, 0);
    lo = 0;
    while (clk_out !== 1'b1 && lo < 50) begin step(); lo++; end
    chk("clk_low_cycles", lo, 13);
    chk("pace_stb1", x_stb, 1);
    chk("pace_x1", x, -3);
    next_stb(n);
    chk("pace_period2", n, 25);
    chk("pace_x2", x, 127);
    next_stb(n);
    chk("pace_period3", n, 25);
    chk("pace_x3", x, -128);
    chk("pace_level0", level, 0);
    next_stb(n);
    chk("pace_period4", n, 25);
    chk("pace_underflow_x", x, 0);
    chk("pace_underflow", underflow, 1);

    // Empty edge: push lands in the tick cycle of an empty FIFO
    repeat (24) step();
    s_valid = 1'b1; s_data = 8'sd42;
    step();
    s_valid = 1'b0;
    chk("edge_stb", x_stb, 1);
    chk("edge_x", x, 0);
    chk("edge_uf", underflow, 1);
    chk("edge_level", level, 1);
    next_stb(n);
    chk("edge_period", n, 25);
    chk("edge_x42", x, 42);
    chk("edge_uf_clear", underflow, 0);
    chk("edge_level0", level, 0);

    // Enable stall at phase 10 for 7 cycles
    repeat (10) step();
    enable = 1'b0;
    repeat (7) step();
    chk("stall_x", x, 42);
    chk("stall_clk_out", clk_out, 1);
    chk("stall_no_stb", x_stb, 0);
    enable = 1'b1;
    next_stb(n);
    chk("stall_gap", n + 17, 32);
    chk("stall_x_after", x, 0);

    // Full: disabled, 9 pushes with s_valid held
    enable = 1'b0; s_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      s_data = 8'(i);
      step();
    end
    chk("full_level", level, 8);
    chk("full_s_ready", s_ready, 0);
    enable = 1'b1;
    next_stb(n);
    chk("full_period", n, 25);
    chk("full_pop_x", x, 1);
    chk("full_no_bypass_level", level, 7);
    chk("full_s_ready_after_pop", s_ready, 1);
    step();
    chk("full_refill_level", level, 8);
    chk("full_refill_s_ready", s_ready, 0);
    s_valid = 1'b0;

    // Mid-operation reset at phase 20
    repeat (19) step();
    rst = 1'b1;
    step();
    chk("mrst_level", level, 0);
    chk("mrst_x", x, 0);
    chk("mrst_no_stb", x_stb, 0);
    chk("mrst_clk_out", clk_out, 0);
    chk("mrst_s_ready", s_ready, 1);
    rst = 1'b0; s_valid = 1'b1; s_data = 8'sd77;
    step();
    s_valid = 1'b0;
    next_stb(n);
    chk("mrst_latency", n + 1, 25);
    chk("mrst_x77", x, 77);
    chk("mrst_uf", underflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
